// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths, writeback-source encoding and the MEM/WB
//               pipeline-register layout for the writeback/register-file slice.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // Writeback source select, encoded to match the wb_selb3 pin values
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } wb_sel_e;

    // Fields carried across the MEM/WB boundary
    typedef struct packed {
        wb_sel_e               wb_sel;
        logic                  rf_en;
        logic [REG_AW-1:0]     rd;
        logic [XLEN-1:0]       alu_out;
        logic [XLEN-1:0]       rdata;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       csr_rdata;
    } memwb_t;

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 32 x XLEN integer register file, one write port and two
//               combinational read ports with write-first bypass. x0 is
//               hard-wired to zero on both the write and read paths.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs_q [NREG];

    // A pending write is visible in the same cycle so decode never sees a
    // stale value; x0 always reads zero regardless of the write port.
    function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (we && (addr == waddr)) begin
            val = wdata;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    // Storage update: reset clears everything and suppresses that edge's write
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Combinational read ports; equal addresses resolve through the same path
    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : MEM/WB pipeline register, writeback source mux and the
//               architectural register file with forwarding-friendly outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        wb_selb3,
    input  logic              rf_enb3,
    input  logic [REG_AW-1:0] rd_b3,
    input  logic [XLEN-1:0]   alu_outb3,
    input  logic [XLEN-1:0]   rdatab3,
    input  logic [XLEN-1:0]   pcb3,
    input  logic [XLEN-1:0]   csr_rdatab3,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_en
);

    memwb_t memwb_q;
    memwb_t memwb_d;

    // Next MEM/WB contents: flush beats stall beats capture. A flush only
    // needs to kill the write; the data fields are left as they were.
    always_comb begin
        memwb_d = memwb_q;
        if (flush) begin
            memwb_d.rf_en = 1'b0;
            memwb_d.rd    = '0;
        end else if (!stall) begin
            memwb_d.wb_sel    = wb_sel_e'(wb_selb3);
            memwb_d.rf_en     = rf_enb3;
            memwb_d.rd        = rd_b3;
            memwb_d.alu_out   = alu_outb3;
            memwb_d.rdata     = rdatab3;
            memwb_d.pc        = pcb3;
            memwb_d.csr_rdata = csr_rdatab3;
        end
    end

    // MEM/WB register; reset overrides flush and stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    // Writeback source select from the registered fields (PC+4 wraps mod 2^32)
    always_comb begin
        wb_data = memwb_q.alu_out;
        case (memwb_q.wb_sel)
            WB_ALU:  wb_data = memwb_q.alu_out;
            WB_MEM:  wb_data = memwb_q.rdata;
            WB_PC4:  wb_data = memwb_q.pc + 32'd4;
            WB_CSR:  wb_data = memwb_q.csr_rdata;
            default: wb_data = memwb_q.alu_out;
        endcase
    end

    assign wb_rd = memwb_q.rd;
    // Writes to x0 are dropped here so forwarding logic never sees them
    assign wb_en = memwb_q.rf_en & (memwb_q.rd != '0);

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, synchronous and active-low; takes effect on the clk rising edge when low.
REQ-003 stall  input  1  hold the MEM/WB register contents.
REQ-004 flush  input  1  inject a bubble into the MEM/WB register.
REQ-005 wb_selb3  input  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 CSR read data.
REQ-006 rf_enb3  input  1  register-file write enable from the MEM-stage control.
REQ-007 rd_b3  input  5  destination register index.
REQ-008 alu_outb3, rdatab3, pcb3, csr_rdatab3  input  32 each  MEM-stage data; rdatab3 is already extended.
REQ-009 rs1, rs2  input  5 each  decode-stage read addresses.
REQ-010 rdata1, rdata2  output  32 each  decode-stage read data.
REQ-011 wb_data  output  32  selected writeback value, for forwarding.
REQ-012 wb_rd  output  5  registered destination index.
REQ-013 wb_en  output  1  registered write enable, forced to 0 when wb_rd = 0.

Function
REQ-014 The MEM/WB register SHALL hold wb_sel, rf_en, rd, alu_out, rdata, pc and csr_rdata.
REQ-015 MEM/WB update priority SHALL be rst > flush > stall > capture.
REQ-016 Flush SHALL clear the registered rf_en and rd to 0 on the next edge; data fields are don't-care.
REQ-017 Stall with no flush SHALL leave all MEM/WB fields unchanged.
REQ-018 Flush asserted together with stall SHALL flush.
REQ-019 Capture SHALL give MEM-to-WB latency of exactly one cycle.
REQ-020 wb_data SHALL be combinational from the registered fields:
- 00 -> alu_out
- 01 -> rdata
- 10 -> pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000)
- 11 -> csr_rdata
REQ-021 The register file SHALL hold 32 x 32 bits.
REQ-022 On every rising edge with wb_en = 1, the register file SHALL write wb_data into register wb_rd.
REQ-023 A write repeated under stall SHALL be idempotent.
REQ-024 Register x0 SHALL never be written and SHALL always read 0.
REQ-025 Reads SHALL be combinational; rdataN SHALL equal wb_data when wb_en = 1, rsN = wb_rd and rsN != 0 (write-first bypass), otherwise the stored value.
REQ-026 rs1 = rs2 SHALL return identical data on both ports, including the bypass case.

Reset
REQ-027 While rst is low at a clock edge, all MEM/WB fields SHALL be cleared to 0; wb_en = 0, wb_rd = 0 and wb_data = 0 follow.
REQ-028 While rst is low at a clock edge, all 32 registers SHALL be cleared to 0.
REQ-029 Reset asserted mid-operation SHALL suppress the register-file write on that edge.
REQ-030 Reset SHALL override flush and stall.
REQ-031 The first capture SHALL occur on the first edge with rst high.

Structure
REQ-032 The package riscv_pkg SHALL hold:
- XLEN = 32
- NREG = 32
- REG_AW = 5
- wb_sel enum: WB_ALU, WB_MEM, WB_PC4, WB_CSR
REQ-033 The register array with bypass SHALL be a sub-module named regfile; the MEM/WB register and writeback mux stay in the top level.
REQ-034 The block SHALL contain no latches, and the x0 check SHALL apply on both the write and read paths.

Verification
REQ-035 Reset: hold rst low 2 cycles with rf_enb3 = 1, rd_b3 = 5, alu_outb3 = 0x1234 -> wb_en = 0; after release, rs1 = 5 reads 0.
REQ-036 Writeback/bypass: wb_selb3 = 00, rd_b3 = 3, alu_outb3 = 0xDEADBEEF -> next cycle rdata1 (rs1 = 3) = 0xDEADBEEF via bypass; it stays 0xDEADBEEF afterwards from storage.
REQ-037 Source mux, all to rd = 7:
- sel 01, rdatab3 = 0xFFFFFF80 -> reads 0xFFFFFF80
- sel 10, pcb3 = 0x100 -> reads 0x104
- sel 10, pcb3 = 0xFFFFFFFC -> reads 0
- sel 11, csr_rdatab3 = 0xA5 -> reads 0xA5
REQ-038 x0: rf_enb3 = 1, rd_b3 = 0, alu_outb3 = 0xFFFFFFFF -> wb_en = 0; rs1 = rs2 = 0 read 0.
REQ-039 Stall/flush:
- stall 3 cycles with a held write of 0x55 to x9 -> x9 = 0x55, no other register changes
- flush and stall together with rf_enb3 = 1, rd_b3 = 9, alu_outb3 = 0x77 -> wb_en = 0 next cycle; x9 stays 0x55
REQ-040 Mid-operation reset: rst low on the edge where wb_en = 1, rd = 4, data 0x99 -> x4 reads 0 after reset.
